// File: rtl/cameralink_uart_phy.sv
// 8N1 UART PHY for the Camera Link serial channel: byte-strobe transmitter
// and mid-bit sampling receiver, full duplex on a single clock.
module cameralink_uart_phy #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       s_axi_aclk,
    input  logic       s_axi_areset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_serial,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_frame_error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    logic [1:0]    r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx_busy;
    logic          r_tx_serial;
    logic          w_tx_bit_done;

    logic          r_rx_sync1;
    logic          r_rx_sync2;
    logic [2:0]    r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_ready;
    logic          r_rx_ferr;
    logic          w_rx_bit_done;

    assign w_tx_bit_done  = (r_tx_cnt == BIT_LAST);
    assign w_rx_bit_done  = (r_rx_cnt == BIT_LAST);
    assign tx_busy        = r_tx_busy;
    assign tx_serial      = r_tx_serial;
    assign rx_data        = r_rx_data;
    assign rx_ready       = r_rx_ready;
    assign rx_frame_error = r_rx_ferr;

    // Next line level is loaded at each bit boundary so tx_serial stays a flop output.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx_busy   <= 1'b0;
            r_tx_serial <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        r_tx_shift  <= tx_data;
                        r_tx_cnt    <= '0;
                        r_tx_bit    <= '0;
                        r_tx_busy   <= 1'b1;
                        r_tx_serial <= 1'b0;
                        r_tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_done) begin
                        r_tx_cnt    <= '0;
                        r_tx_serial <= r_tx_shift[0];
                        r_tx_shift  <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state  <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_done) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_serial <= 1'b1;
                            r_tx_state  <= TX_STOP;
                        end else begin
                            r_tx_bit    <= r_tx_bit + 3'd1;
                            r_tx_serial <= r_tx_shift[0];
                            r_tx_shift  <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_done) begin
                        r_tx_cnt   <= '0;
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Start sample lands one cycle past the half bit, which keeps the stop
    // sample inside the stop bit for a receiver running slightly slow.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_ready <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_sync1 <= rx_serial;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_ready <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync2) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_BIT) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_bit_done) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        else r_rx_bit <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_bit_done) begin
                        r_rx_cnt <= '0;
                        if (r_rx_sync2) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_ready <= 1'b1;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_ferr  <= 1'b1;
                            r_rx_state <= RX_BREAK;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (r_rx_sync2) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cameralink_uart_phy.sv
// Scoreboard bench for cameralink_uart_phy at 16 clocks per bit: directed
// frames push expected results, independent TX and RX monitors check them.
module tb_cameralink_uart_phy;
    typedef struct {
        logic       ferr;
        logic [7:0] data;
    } rx_exp_t;

    logic       clk = 1'b0;
    logic       s_axi_areset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_serial;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_frame_error;

    int n_checks = 0;
    int n_fail   = 0;

    rx_exp_t    rx_q[$];
    logic [9:0] tx_q[$];

    always #5 clk = ~clk;

    cameralink_uart_phy #(.CLKS_PER_BIT(16)) dut (
        .s_axi_aclk     (clk),
        .s_axi_areset   (s_axi_areset),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_busy        (tx_busy),
        .tx_serial      (tx_serial),
        .rx_serial      (rx_serial),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .rx_frame_error (rx_frame_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_rx(input logic ferr, input logic [7:0] d);
        rx_exp_t e;
        e.ferr = ferr;
        e.data = d;
        rx_q.push_back(e);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop, input int per);
        rx_serial = 1'b0;
        cyc(per);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            cyc(per);
        end
        rx_serial = stop;
        cyc(per);
    endtask

    // RX monitor: every ready/error pulse must match the head of the queue.
    initial begin : rx_mon
        rx_exp_t e;
        forever begin
            @(negedge clk);
            if (s_axi_areset === 1'b0 && (rx_ready === 1'b1 || rx_frame_error === 1'b1)) begin
                check("rx_pulse_exclusive", 32'(rx_ready & rx_frame_error), 32'd0);
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: ready=%0b ferr=%0b data=0x%0h, expected no pulse",
                             rx_ready, rx_frame_error, rx_data);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_ferr", 32'(rx_frame_error), 32'(e.ferr));
                    check("rx_data", 32'(rx_data), 32'(e.data));
                end
            end
        end
    end

    // TX monitor: records one mid-bit sample per bit for the whole busy window.
    initial begin : tx_mon
        logic [9:0] bits;
        logic       cur;
        logic       steady;
        int         n;
        forever begin
            @(negedge clk);
            if (s_axi_areset === 1'b0 && tx_busy === 1'b1) begin
                bits   = '0;
                n      = 0;
                steady = 1'b1;
                cur    = 1'b1;
                while (tx_busy === 1'b1 && s_axi_areset === 1'b0 && n < 200) begin
                    if (n % 16 == 0) cur = tx_serial;
                    else if (tx_serial !== cur) steady = 1'b0;
                    if (n % 16 == 8 && n < 160) bits[n/16] = tx_serial;
                    n++;
                    @(negedge clk);
                end
                if (s_axi_areset === 1'b0) begin
                    if (tx_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: frame 0x%0h busy %0d cycles, expected no frame", bits, n);
                    end else begin
                        check("tx_frame_bits", 32'(bits), 32'(tx_q.pop_front()));
                        check("tx_busy_cycles", 32'(n), 32'd160);
                        check("tx_bit_steady", 32'(steady), 32'd1);
                        check("tx_idle_after", 32'(tx_serial), 32'd1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] rxf;
        s_axi_areset = 1'b1;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        rx_serial    = 1'b1;
        cyc(5);
        check("rst_tx_serial", 32'(tx_serial), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_rx_ferr", 32'(rx_frame_error), 32'd0);
        s_axi_areset = 1'b0;
        cyc(5);

        // 0xA5 -> line 0,1,0,1,0,0,1,0,1,1; extra 0xFF strobe mid-frame is dropped
        tx_q.push_back(10'h34A);
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0;
        cyc(49);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0;
        tx_data  = 8'h00;
        cyc(140);

        exp_rx(1'b0, 8'h3C);
        rx_send(8'h3C, 1'b1, 16);
        cyc(20);

        exp_rx(1'b0, 8'h00);
        exp_rx(1'b0, 8'hFF);
        rx_send(8'h00, 1'b1, 16);
        rx_send(8'hFF, 1'b1, 16);
        cyc(20);

        rx_serial = 1'b0;
        cyc(4);
        rx_serial = 1'b1;
        cyc(30);

        // Bad stop bit leaves rx_data at the previous byte
        exp_rx(1'b1, 8'hFF);
        rx_send(8'h55, 1'b0, 16);
        cyc(40);
        rx_serial = 1'b1;
        cyc(20);
        exp_rx(1'b0, 8'h81);
        rx_send(8'h81, 1'b1, 16);
        cyc(20);

        // Slow remote (17 clocks per bit) while transmitting 0x12
        tx_q.push_back(10'h224);
        exp_rx(1'b0, 8'hA7);
        fork
            begin
                tx_data  = 8'h12;
                tx_start = 1'b1;
                cyc(1);
                tx_start = 1'b0;
            end
            rx_send(8'hA7, 1'b1, 17);
        join
        cyc(40);

        // Reset lands in TX data bit 3 (of 0xC3, a 0) and RX data bit 4
        rxf = {1'b1, 8'h69, 1'b0};
        for (int c = 0; c < 85; c++) begin
            rx_serial = rxf[c/16];
            if (c == 10) begin
                tx_data  = 8'hC3;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            cyc(1);
        end
        s_axi_areset = 1'b1;
        @(negedge clk);
        check("tx_pre_reset_bit3", 32'(tx_serial), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("tx_serial_after_reset", 32'(tx_serial), 32'd1);
        check("tx_busy_after_reset", 32'(tx_busy), 32'd0);
        cyc(1);
        s_axi_areset = 1'b0;
        rx_serial    = 1'b1;
        cyc(5);
        check("rx_data_after_reset", 32'(rx_data), 32'h00);

        tx_q.push_back(10'h2B4);
        exp_rx(1'b0, 8'hE7);
        fork
            begin
                tx_data  = 8'h5A;
                tx_start = 1'b1;
                cyc(1);
                tx_start = 1'b0;
            end
            rx_send(8'hE7, 1'b1, 16);
        join
        cyc(40);

        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cameralink_uart_phy.md
# cameralink_uart_phy

Bit-level 8N1 UART transmitter/receiver for the Camera Link serial channel (SerTFG/SerTC). Sits directly downstream of the AXI-to-UART bridge: consumes its `tx_start`/`tx_data` byte strobes, drives the camera's serial line, deserializes the camera's replies and presents them as `rx_data` with a one-cycle `rx_ready` pulse. Both directions run independently, full duplex, on the AXI clock.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per UART bit (100 MHz / 9600 baud). Legal range 16..65535. Counters are `$clog2(CLKS_PER_BIT)` bits wide.
- `s_axi_aclk`  in  1  single clock for all logic.
- `s_axi_areset`  in  1  reset; synchronous, active-high.
- `tx_start`  in  1  byte-send strobe; sampled only while `tx_busy`=0.
- `tx_data`  in  8  byte to send; captured in the cycle `tx_start` is accepted.
- `tx_busy`  out  1  high while a frame is being shifted out.
- `tx_serial`  out  1  serial line to camera (SerTC); idle high.
- `rx_serial`  in  1  serial line from camera (SerTFG); asynchronous.
- `rx_data`  out  8  last correctly framed received byte.
- `rx_ready`  out  1  one-cycle pulse: new byte valid on `rx_data`.
- `rx_frame_error`  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- Reset values: `tx_serial`=1, `tx_busy`=0, `rx_data`=0x00, `rx_ready`=0, `rx_frame_error`=0; both synchronizer flops =1; both FSMs in IDLE, all counters 0. Reset mid-frame aborts immediately; `tx_serial` returns high the cycle after reset is sampled.
- All outputs registered.
- TX FSM: TX_IDLE -> TX_START -> TX_DATA (8 bits, LSB first) -> TX_STOP -> TX_IDLE.
  - TX_IDLE: `tx_start`=1 latches `tx_data` into shift register; next cycle `tx_serial`=0, `tx_busy`=1.
  - Each bit held exactly `CLKS_PER_BIT` cycles. Stop bit = 1.
  - `tx_busy` falls in the cycle after the stop bit's last cycle; `tx_serial` stays 1.
  - `tx_start` while `tx_busy`=1 is ignored (no queueing). Upstream bridge pulses per AXI beat; software must poll/pace.
- RX path: `rx_serial` passes a 2-flop synchronizer; FSM uses synchronized value only.
- RX FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE, plus RX_BREAK.
  - RX_IDLE: synchronized line low -> RX_START, counter cleared.
  - RX_START: after `CLKS_PER_BIT/2` cycles (integer divide) sample; low -> RX_DATA; high -> glitch, back to RX_IDLE, no pulse.
  - RX_DATA: sample every `CLKS_PER_BIT` cycles, shift in LSB first, 8 samples.
  - RX_STOP: sample after `CLKS_PER_BIT` cycles. High -> `rx_data` updated, `rx_ready` pulsed, -> RX_IDLE (mid-stop-bit, so back-to-back frames are caught). Low -> `rx_frame_error` pulsed, `rx_data` unchanged, -> RX_BREAK.
  - RX_BREAK: wait until synchronized line high, then RX_IDLE.
- `rx_ready` and `rx_frame_error` never assert in the same cycle. No RX buffering beyond `rx_data`: a new byte overwrites the previous one; overflow is the consumer's problem.

## Timing
- TX: `tx_start` accepted at cycle 0 -> start bit cycles 1..C (C=`CLKS_PER_BIT`); data bit i occupies cycles (i+1)·C+1..(i+2)·C; stop bit 9C+1..10C; `tx_busy`=1 for cycles 1..10C, 0 at 10C+1. Earliest next accepted `tx_start` at cycle 10C+1 (start bit at 10C+2).
- RX: let cycle 0 be the first rising edge at which `rx_serial`=0 is captured by the first sync flop. RX_START entered at cycle 2; `rx_ready` asserts at cycle 2 + C/2 + 9C + 1 (±1 allowed for implementation pipelining; must be fixed per build).
- Sampling point is the middle of each bit ±1 cycle; tolerates ±4 % baud mismatch at C≥16.
- TX and RX fully independent; simultaneous TX and RX activity required to work.

## Test plan
- Reset: hold `s_axi_areset`=1 for 5 cycles -> `tx_serial`=1, `tx_busy`=0, `rx_data`=0x00, no pulses.
- TX frame, C=16: `tx_start` with `tx_data`=0xA5 -> `tx_serial` sequence 0,1,0,1,0,0,1,0,1,1 each 16 cycles; `tx_busy` high exactly 160 cycles; extra `tx_start` (0xFF) at cycle 50 ignored.
- RX frame, C=16: drive 0x3C 8N1 at exact baud -> single `rx_ready` pulse, `rx_data`=0x3C; then back-to-back 0x00 and 0xFF with no idle gap -> two pulses, values 0x00 then 0xFF.
- RX glitch/framing: 4-cycle low glitch -> no pulse, FSM back in RX_IDLE; frame 0x55 with stop bit 0 -> `rx_frame_error` one pulse, `rx_data` keeps previous value, no `rx_ready`; line held low 40 cycles then high -> next valid 0x81 received.
- Baud tolerance and duplex: RX bit period 17 cycles (C=16) while TX sends 0x12 -> `rx_data` correct, TX waveform unchanged.
- Reset mid-frame: assert reset at TX data bit 3 and RX data bit 4 -> `tx_serial`=1 next cycle, no `rx_ready`; subsequent full frames work.
